vga_timing_sequencer: RTL
=========================

# vga_timing_sequencer

Sequences the horizontal and vertical scan of the video card's VGA output. From one oscillator clock it produces a programmable pixel tick, walks a horizontal and a vertical timing FSM (active, front porch, sync, back porch), and drives H_SYNC, V_SYNC, a display-enable and pixel coordinates. It sits between the oscillator and the pixel/colour logic in the top level, and it replaces the free-running, comparator-decoded horizontal counter.

## Interface
- PIX_DIV, 1: osc_clk cycles per pixel tick (1..16).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in ticks.
- H_SYNC_W, 96: horizontal sync width, in ticks.
- H_BP, 48: horizontal back porch, in ticks.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC_W, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: asserted sync level (0 = active-low).

Ports:
- osc_clk  in  1  The single clock. All logic is on the rising edge.
- RESET  in  1  Synchronous, active-low reset.
- run  in  1  Level. High enables frame generation.
- H_SYNC  out  1  Horizontal sync, registered.
- V_SYNC  out  1  Vertical sync, registered.
- video_on  out  1  High while both axes are in ACTIVE.
- pixel_x  out  11  Horizontal position within the line.
- pixel_y  out  10  Vertical position within the frame.
- line_start  out  1  One-cycle pulse at x=0 of each line.
- frame_start  out  1  One-cycle pulse at x=0, y=0.
- busy  out  1  High while a frame is in progress.

## Operation
**Tick divider**
- The divider counts 0..PIX_DIV-1.
- tick is high in the cycle where the count equals PIX_DIV-1.
- With PIX_DIV=1, tick is high every cycle.
- The divider is cleared while in IDLE.

**Axis FSM (one per axis)**
- States: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
- pos counts 0..TOTAL-1, where TOTAL = ACTIVE+FP+SYNC_W+BP.
- A transition occurs when pos reaches the last value of the current state.
- At pos = TOTAL-1 the axis wraps: pos goes to 0, state goes to ACTIVE, and wrap pulses.
- The horizontal axis advances on tick.
- The vertical axis advances on tick AND horizontal wrap.

**Control FSM: IDLE, RUN**
- IDLE → RUN: on tick with run=1. The transition emits frame_start.
- RUN → IDLE: when a frame completes (horizontal wrap AND vertical wrap) with run=0. The axes are left at 0.
- run going low mid-frame never truncates the frame. It is sampled only at frame end.
- run pulsing low-then-high within a frame has no effect.

**Outputs**
- H_SYNC = SYNC_POL when the horizontal FSM is in SYNC; otherwise !SYNC_POL.
- V_SYNC is formed the same way from the vertical FSM.
- In IDLE, both syncs are inactive and video_on=0.
- pixel_x equals horizontal pos and pixel_y equals vertical pos, including during blanking.

## Timing
- **Reset (RESET=0 sampled on an edge):**
  - control FSM=IDLE; both axis FSMs=ACTIVE with pos=0; divider=0.
  - H_SYNC=V_SYNC=!SYNC_POL.
  - video_on=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, busy=0.
- Reset asserted mid-frame aborts the frame immediately. There is no drain.
- **Output latency:** every output is registered and reflects the FSM/pos state one osc_clk after that state is entered. Sync and video_on are therefore aligned with pixel_x/pixel_y.
- **Pulse width:** line_start and frame_start are one osc_clk wide regardless of PIX_DIV.
  - line_start fires on the tick that enters x=0.
  - frame_start additionally requires y=0.
- **busy:** rises with the first frame_start and falls in the cycle after RUN→IDLE.
- **Widths:**
  - pos registers are 11 bits (h) and 10 bits (v).
  - Totals are elaborated as integer constants and must fit those widths.
  - No arithmetic overflow is reachable.

## Structure
- A shared package vga_timing_pkg holds:
  - the axis state typedef (ACTIVE, FRONT, SYNC, BACK, 2-bit);
  - the control state typedef (IDLE, RUN);
  - the 640x480@60 default constants.
- Sub-module vga_axis_fsm (params ACTIVE/FP/SYNC_W/BP, width; ports advance, pos, state, wrap) is instantiated twice.
- The top holds the divider, the control FSM and the output registers.

## Test plan
Small configuration used throughout: PIX_DIV=2; H 4/1/2/1 (total 8); V 3/1/1/1 (total 6); SYNC_POL=0.
1. **Reset, run=0 for 20 cycles** → H_SYNC=V_SYNC=1, video_on=0, pixel_x=pixel_y=0, busy=0 throughout.
2. **run=1** →
   - frame_start occurs once;
   - pixel_x steps 0..7 every 2 cycles;
   - video_on is high for x 0..3 on y 0..2;
   - H_SYNC is low exactly for x=5,6 (4 cycles);
   - line_start every 16 cycles.
3. **Full frame** →
   - V_SYNC is low exactly while y=4 (16 cycles);
   - frame period is 96 cycles;
   - the second frame_start comes exactly 96 cycles after the first.
4. **run dropped at y=1, x=2** → the frame completes through y=5, x=7, then IDLE; busy falls; no further frame_start.
5. **run low for 3 cycles mid-frame, then high** → the frame continues uninterrupted and the next frame starts on schedule.
6. **RESET=0 asserted at y=4 (V_SYNC low)** → on the next edge V_SYNC=1, pixel_y=0, busy=0; with run=1 after release, frame_start occurs.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_pkg : shared state encodings and 640x480@60 defaults for VGA timing
// Revision: 1.0
// ----------------------------------------------------------------------------
package vga_timing_pkg;

  typedef logic [1:0] axis_state_t;
  localparam axis_state_t AX_ACTIVE = 2'd0;
  localparam axis_state_t AX_FRONT  = 2'd1;
  localparam axis_state_t AX_SYNC   = 2'd2;
  localparam axis_state_t AX_BACK   = 2'd3;

  typedef logic [0:0] ctrl_state_t;
  localparam ctrl_state_t CS_IDLE = 1'b0;
  localparam ctrl_state_t CS_RUN  = 1'b1;

  localparam int H_POS_W = 11;
  localparam int V_POS_W = 10;

  localparam int DEF_PIX_DIV  = 1;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC_W = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC_W = 2;
  localparam int DEF_V_BP     = 33;

endpackage
`default_nettype wire

// File: rtl/vga_axis_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_axis_fsm : one scan axis (active / front porch / sync / back porch)
// Revision: 1.0
// ----------------------------------------------------------------------------
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC_W = DEF_H_SYNC_W,
  parameter int BP     = DEF_H_BP,
  parameter int WIDTH  = H_POS_W
) (
  input  logic             osc_clk,
  input  logic             RESET,
  input  logic             advance,
  output logic [WIDTH-1:0] pos,
  output axis_state_t      state,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC_W + BP;
  localparam logic [WIDTH-1:0] c_FRONT_START = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] c_SYNC_START  = WIDTH'(ACTIVE + FP);
  localparam logic [WIDTH-1:0] c_BACK_START  = WIDTH'(ACTIVE + FP + SYNC_W);
  localparam logic [WIDTH-1:0] c_LAST        = WIDTH'(TOTAL - 1);

  logic [WIDTH-1:0] r_pos;
  axis_state_t      r_state;
  logic [WIDTH-1:0] w_pos_nxt;
  axis_state_t      w_state_nxt;

  // Next state is the region containing the next position, so a state
  // changes exactly when pos leaves the last value of the current region.
  always_comb begin
    w_pos_nxt = (r_pos == c_LAST) ? '0 : r_pos + 1'b1;
    if (w_pos_nxt < c_FRONT_START) begin
      w_state_nxt = AX_ACTIVE;
    end else if (w_pos_nxt < c_SYNC_START) begin
      w_state_nxt = AX_FRONT;
    end else if (w_pos_nxt < c_BACK_START) begin
      w_state_nxt = AX_SYNC;
    end else begin
      w_state_nxt = AX_BACK;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (!RESET) begin
      r_pos   <= '0;
      r_state <= AX_ACTIVE;
    end else if (advance) begin
      r_pos   <= w_pos_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign pos   = r_pos;
  assign state = r_state;
  assign wrap  = advance && (r_pos == c_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_sequencer : pixel-tick divider, run control and registered VGA outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
module vga_timing_sequencer
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC_W = DEF_H_SYNC_W,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC_W = DEF_V_SYNC_W,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        osc_clk,
  input  logic        RESET,
  input  logic        run,
  output logic        H_SYNC,
  output logic        V_SYNC,
  output logic        video_on,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        busy
);

  localparam logic [3:0] c_DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0]         r_div;
  ctrl_state_t        r_ctrl;
  logic               r_ls_pre;
  logic               r_fs_pre;

  logic               w_tick;
  logic               w_running;
  logic               w_start;
  logic               w_stop;
  logic               w_h_adv;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_ls_evt;
  logic               w_fs_evt;
  logic [H_POS_W-1:0] w_h_pos;
  logic [V_POS_W-1:0] w_v_pos;
  axis_state_t        w_h_state;
  axis_state_t        w_v_state;

  assign w_tick    = (r_div == c_DIV_LAST);
  assign w_running = (r_ctrl == CS_RUN);
  assign w_start   = (r_ctrl == CS_IDLE) && w_tick && run;
  assign w_h_adv   = w_tick && w_running;
  assign w_stop    = w_v_wrap && !run;
  // Events mark the edge that enters x=0; they are delayed one more stage
  // below so the pulses line up with the registered pixel coordinates.
  assign w_ls_evt  = w_start || (w_h_wrap && !w_stop);
  assign w_fs_evt  = w_start || (w_v_wrap && run);

  vga_axis_fsm #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC_W (H_SYNC_W),
    .BP     (H_BP),
    .WIDTH  (H_POS_W)
  ) u_h_axis (
    .osc_clk (osc_clk),
    .RESET   (RESET),
    .advance (w_h_adv),
    .pos     (w_h_pos),
    .state   (w_h_state),
    .wrap    (w_h_wrap)
  );

  vga_axis_fsm #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC_W (V_SYNC_W),
    .BP     (V_BP),
    .WIDTH  (V_POS_W)
  ) u_v_axis (
    .osc_clk (osc_clk),
    .RESET   (RESET),
    .advance (w_h_wrap),
    .pos     (w_v_pos),
    .state   (w_v_state),
    .wrap    (w_v_wrap)
  );

  // Divider holds at zero in IDLE until run is requested.
  always_ff @(posedge osc_clk) begin
    if (!RESET) begin
      r_div <= '0;
    end else if ((r_ctrl == CS_IDLE) && !run) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (!RESET) begin
      r_ctrl <= CS_IDLE;
    end else if (w_start) begin
      r_ctrl <= CS_RUN;
    end else if (w_running && w_stop) begin
      r_ctrl <= CS_IDLE;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (!RESET) begin
      H_SYNC      <= ~SYNC_POL;
      V_SYNC      <= ~SYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      busy        <= 1'b0;
      r_ls_pre    <= 1'b0;
      r_fs_pre    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      H_SYNC      <= (w_running && (w_h_state == AX_SYNC)) ? SYNC_POL : ~SYNC_POL;
      V_SYNC      <= (w_running && (w_v_state == AX_SYNC)) ? SYNC_POL : ~SYNC_POL;
      video_on    <= w_running && (w_h_state == AX_ACTIVE) && (w_v_state == AX_ACTIVE);
      pixel_x     <= w_h_pos;
      pixel_y     <= w_v_pos;
      busy        <= w_running;
      r_ls_pre    <= w_ls_evt;
      r_fs_pre    <= w_fs_evt;
      line_start  <= r_ls_pre;
      frame_start <= r_fs_pre;
    end
  end

endmodule
`default_nettype wire
